// File: rtl/regfile_scoreboard_pkg.sv
// Shared types and default sizes for the integer register file and its
// in-flight-write scoreboard.
package regfile_scoreboard_pkg;

    typedef logic [4:0]  u5;
    typedef logic [63:0] u64;

    localparam int NREGS  = 32;
    localparam int PEND_W = 2;

    typedef logic [PEND_W-1:0] pend_t;

endpackage

// File: rtl/regfile_pend_ctr.sv
// One per-register pending-write counter. Counts destinations that have been
// issued but not yet written back. The decrement is ignored when the count is
// already zero, so a writeback with no reservation cannot underflow it.
// Flush clears the count and takes priority over increment and decrement.
module regfile_pend_ctr #(
    parameter int W = regfile_scoreboard_pkg::PEND_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    input  logic         flush,
    output logic [W-1:0] count,
    output logic         last
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         dec_eff;

    // Next count: flush wins; a simultaneous inc and dec cancel out.
    always_comb begin
        dec_eff = dec && (count_q != '0);
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (inc && !dec_eff) begin
            count_d = count_q + W'(1);
        end else if (dec_eff && !inc) begin
            count_d = count_q - W'(1);
        end
    end

    // Counter register, cleared immediately by the asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign last  = (count_q == W'(1));

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural integer register file (x0 hard-wired to zero) with a
// per-register scoreboard of outstanding writes. Reads bypass the writeback
// port in the same cycle. Stall is raised for a RAW hazard on a consumed
// source, or when an issued destination's counter is already full.
module regfile_scoreboard #(
    parameter int NREGS  = regfile_scoreboard_pkg::NREGS,
    parameter int PEND_W = regfile_scoreboard_pkg::PEND_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbEn,
    input  logic [4:0]  wd,
    input  logic [63:0] wbData,
    input  logic        flush,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic        use1,
    input  logic        use2,
    output logic [63:0] rd1,
    output logic [63:0] rd2,
    input  logic        issueEn,
    input  logic        issueWr,
    input  logic [4:0]  issueRd,
    output logic        stall
);

    import regfile_scoreboard_pkg::*;

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    u64                regs_q [NREGS];
    u64                regs_d [NREGS];
    logic [PEND_W-1:0] pend   [NREGS];
    logic              last_v [NREGS];
    logic [NREGS-1:1]  inc;
    logic [NREGS-1:1]  dec;
    logic              busy1;
    logic              busy2;
    logic              sat_stall;

    // Next register contents: single writeback port, writes to x0 dropped.
    always_comb begin
        regs_d = regs_q;
        if (wbEn && (wd != 5'd0)) begin
            regs_d[wd] = wbData;
        end
    end

    // Register storage; reset clears every entry at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Operand reads with same-cycle writeback bypass; x0 always reads zero.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 != 5'd0) begin
            rd1 = (wbEn && (wd == ra1)) ? wbData : regs_q[ra1];
        end
        if (ra2 != 5'd0) begin
            rd2 = (wbEn && (wd == ra2)) ? wbData : regs_q[ra2];
        end
    end

    // Per-register reserve/retire strobes. An issue squashed by flush or held
    // by stall does not reserve its destination.
    always_comb begin
        inc = '0;
        dec = '0;
        for (int r = 1; r < NREGS; r++) begin
            inc[r] = issueEn && issueWr && (issueRd == r[4:0]) && !stall && !flush;
            dec[r] = wbEn && (wd == r[4:0]);
        end
    end

    assign pend[0]   = '0;
    assign last_v[0] = 1'b0;

    for (genvar g = 1; g < NREGS; g++) begin : g_pend
        regfile_pend_ctr #(
            .W(PEND_W)
        ) u_ctr (
            .clk  (clk),
            .rst  (rst),
            .inc  (inc[g]),
            .dec  (dec[g]),
            .flush(flush),
            .count(pend[g]),
            .last (last_v[g])
        );
    end

    // Hazard detection. The last outstanding write retiring this cycle is
    // covered by the bypass, so it does not stall. A full counter stalls a new
    // issue unless a writeback to the same register frees a slot this cycle.
    always_comb begin
        busy1 = use1 && (ra1 != 5'd0) && (pend[ra1] != '0)
                && !(wbEn && (wd == ra1) && last_v[ra1]);
        busy2 = use2 && (ra2 != 5'd0) && (pend[ra2] != '0)
                && !(wbEn && (wd == ra2) && last_v[ra2]);
        sat_stall = issueEn && issueWr && (issueRd != 5'd0)
                    && (pend[issueRd] == PEND_MAX)
                    && !(wbEn && (wd == issueRd));
        stall = (busy1 || busy2 || sat_stall) && !flush;
    end

endmodule
